// File: rtl/test_obf.sv
// rtl/test_obf.sv - key-locked ITC'99 b01 serial comparator FSM; lock prefix enabled by `TEST_OBF_LOCK_EN
module test_obf (
  input  logic clock,
  input  logic reset,
  input  logic line1,
  input  logic line2,
  output logic outp,
  output logic overflw
);

  localparam logic [3:0] S_A   = 4'd0;
  localparam logic [3:0] S_B   = 4'd1;
  localparam logic [3:0] S_C   = 4'd2;
  localparam logic [3:0] S_E   = 4'd3;
  localparam logic [3:0] S_F   = 4'd4;
  localparam logic [3:0] S_G   = 4'd5;
  localparam logic [3:0] S_WF0 = 4'd6;
  localparam logic [3:0] S_WF1 = 4'd7;

`ifdef TEST_OBF_LOCK_EN
  localparam logic [3:0] S_L0  = 4'd8;
  localparam logic [3:0] S_L1  = 4'd9;
  localparam logic [3:0] S_L2  = 4'd10;
  localparam logic [3:0] S_L3  = 4'd11;
  // Unlock vectors {line2,line1}, K0 in the low bits
  localparam logic [7:0] KEY   = 8'b00_11_01_10;
  localparam logic [3:0] S_RST = S_L0;
`else
  localparam logic [3:0] S_RST = S_A;
`endif

  logic [3:0] state_q, state_d;
  logic       outp_q, outp_d;
  logic       overflw_q, overflw_d;
  logic       x, o, n;

  assign x = line1 ^ line2;
  assign o = line1 | line2;
  assign n = line1 & line2;

`ifdef TEST_OBF_LOCK_EN
  logic [1:0] v;
  assign v = {line2, line1};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_RST;
      outp_q    <= 1'b0;
      overflw_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      outp_q    <= outp_d;
      overflw_q <= overflw_d;
    end
  end

  always_comb begin
    state_d = S_RST;
    case (state_q)
      S_A, S_E: state_d = n ? S_F : S_B;
      S_B:      state_d = n ? S_G : S_C;
      S_F:      state_d = o ? S_G : S_C;
      S_C:      state_d = n ? S_WF1 : S_WF0;
      S_G:      state_d = o ? S_WF1 : S_WF0;
      S_WF0:    state_d = n ? S_E : S_A;
      S_WF1:    state_d = o ? S_E : S_A;
`ifdef TEST_OBF_LOCK_EN
      // A mismatch drops straight to L0 without re-testing against K0
      S_L0:     state_d = (v == KEY[1:0]) ? S_L1 : S_L0;
      S_L1:     state_d = (v == KEY[3:2]) ? S_L2 : S_L0;
      S_L2:     state_d = (v == KEY[5:4]) ? S_L3 : S_L0;
      S_L3:     state_d = (v == KEY[7:6]) ? S_A  : S_L0;
`endif
      default:  state_d = S_RST;
    endcase
  end

  always_comb begin
    outp_d    = 1'b0;
    overflw_d = 1'b0;
    case (state_q)
      S_A, S_C, S_WF0:         outp_d = x;
      S_E: begin
        outp_d    = x;
        overflw_d = 1'b1;
      end
      S_B, S_F, S_G, S_WF1:    outp_d = ~x;
      default: begin
        outp_d    = 1'b0;
        overflw_d = 1'b0;
      end
    endcase
  end

  assign outp    = outp_q;
  assign overflw = overflw_q;

endmodule

// File: tb/tb_test_obf.sv
// tb/tb_test_obf.sv - scoreboard bench for test_obf with a table-driven reference model
module tb_test_obf;

  logic clock;
  logic reset;
  logic line1;
  logic line2;
  logic outp;
  logic overflw;

  test_obf dut (
    .clock   (clock),
    .reset   (reset),
    .line1   (line1),
    .line2   (line2),
    .outp    (outp),
    .overflw (overflw)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef TEST_OBF_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0] e;
    string      tag;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   issued = 0;

  // Functional states indexed A,B,C,E,F,G,WF0,WF1
  int         inv_t [8] = '{0, 1, 0, 0, 1, 1, 0, 1};
  int         ovf_t [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
  int         useo_t[8] = '{0, 0, 0, 0, 1, 1, 0, 1};
  int         nt_t  [8] = '{4, 5, 7, 4, 5, 7, 3, 3};
  int         nf_t  [8] = '{1, 2, 6, 1, 2, 6, 0, 0};
  logic [1:0] key_t [4] = '{2'b10, 2'b01, 2'b11, 2'b00};

  bit m_locked = LOCK_EN;
  int m_idx = 0;
  int m_fs = 0;

  task automatic model_step(input bit rst, input logic [1:0] v, output logic [1:0] r);
    bit x, o, n, cond;
    x = v[0] ^ v[1];
    o = v[0] | v[1];
    n = v[0] & v[1];
    if (rst) begin
      m_locked = LOCK_EN;
      m_idx = 0;
      m_fs = 0;
      r = 2'b00;
    end else if (m_locked) begin
      r = 2'b00;
      if (v == key_t[m_idx]) begin
        m_idx = m_idx + 1;
        if (m_idx == 4) begin
          m_locked = 1'b0;
          m_fs = 0;
        end
      end else begin
        m_idx = 0;
      end
    end else begin
      r = {x ^ inv_t[m_fs][0], ovf_t[m_fs][0]};
      cond = (useo_t[m_fs] != 0) ? o : n;
      m_fs = cond ? nt_t[m_fs] : nf_t[m_fs];
    end
  endtask

  // v is {line2,line1}; ex is {outp,overflw} and overrides the model when use_exp is set
  task automatic drive(input bit rst, input logic [1:0] v, input string tag,
                       input bit use_exp, input logic [1:0] ex);
    logic [1:0] m;
    exp_t it;
    @(negedge clock);
    reset = rst;
    line2 = v[1];
    line1 = v[0];
    model_step(rst, v, m);
    it.e = use_exp ? ex : m;
    it.tag = tag;
    it.idx = issued;
    issued++;
    exp_q.push_back(it);
  endtask

  task automatic key_seq(input string tag);
    drive(0, 2'b10, tag, 1, 2'b00);
    drive(0, 2'b01, tag, 1, 2'b00);
    drive(0, 2'b11, tag, 1, 2'b00);
    drive(0, 2'b00, tag, 1, 2'b00);
  endtask

  initial begin
    exp_t it;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        compared++;
        if ({outp, overflw} !== it.e) begin
          mismatched++;
          $display("FAIL %s #%0d: outp/overflw got %b%b required %b", it.tag, it.idx,
                   outp, overflw, it.e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    line1 = 1'b0;
    line2 = 1'b0;
    for (int i = 0; i < 10; i++) drive(1, 2'b00, "reset_hold", 1, 2'b00);

    if (LOCK_EN) begin
      key_seq("unlock");
      drive(0, 2'b01, "func_A", 1, 2'b10);
      drive(0, 2'b01, "func_B", 1, 2'b00);
      drive(0, 2'b01, "func_C", 1, 2'b10);
      drive(0, 2'b11, "func_WF0", 1, 2'b00);
      drive(0, 2'b00, "func_E", 1, 2'b01);

      drive(1, 2'b00, "reset_mid", 1, 2'b00);
      drive(0, 2'b10, "wrong_key", 1, 2'b00);
      drive(0, 2'b01, "wrong_key", 1, 2'b00);
      drive(0, 2'b00, "wrong_key", 1, 2'b00);
      key_seq("rekey");
      drive(0, 2'b11, "after_key_A", 1, 2'b00);
      drive(0, 2'b00, "after_key_F", 1, 2'b10);

      drive(1, 2'b00, "relock_reset", 1, 2'b00);
      drive(0, 2'b01, "relocked", 1, 2'b00);
      drive(0, 2'b01, "relocked", 1, 2'b00);
      key_seq("unlock_rand");
    end else begin
      drive(0, 2'b11, "nolock_A", 1, 2'b00);
      drive(0, 2'b11, "nolock_F", 1, 2'b10);
      drive(0, 2'b00, "nolock_G", 0, 2'b00);
      drive(0, 2'b01, "nolock_WF0", 0, 2'b00);
      drive(1, 2'b11, "reset_mid", 1, 2'b00);
      drive(0, 2'b01, "nolock_reA", 1, 2'b10);
      drive(0, 2'b11, "nolock_B", 1, 2'b10);
      drive(0, 2'b00, "nolock_G2", 1, 2'b10);
    end

    for (int i = 0; i < 1200; i++) drive(0, 2'($urandom_range(0, 3)), "random", 0, 2'b00);

    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #2;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: pending %0d required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
